frequency_generator: RTL and testbench

FREQUENCY_GENERATOR -- requirements
Module: frequency_generator

---
 rtl/frequency_generator_pkg.sv | 17 +
 rtl/freq_div.sv | 85 ++++++++
 rtl/frequency_generator.sv | 150 +++++++++++++++
 tb/tb_frequency_generator.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frequency_generator_pkg.sv
// Shared widths, default clock rate and state encodings for the frequency generator.
package frequency_generator_pkg;

    localparam int unsigned FG_W      = 32;
    localparam int unsigned FG_CLK_HZ = 100_000_000;

    typedef enum logic {
        StStop,
        StRun
    } fsm_state_e;

    typedef enum logic {
        DivIdle,
        DivBusy
    } div_state_e;

endpackage

// File: rtl/freq_div.sv
// W-bit restoring unsigned divider: one quotient bit per cycle, done pulses W cycles after start.
module freq_div
    import frequency_generator_pkg::*;
#(
    parameter int unsigned W = FG_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W:0]   divisor_i,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(W);

    div_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_q, rem_d;
    logic [W:0]    div_q, div_d;
    logic [W-1:0]  quo_q, quo_d;
    logic          done_q, done_d;
    logic [W+1:0]  rem_sh;

    // Dividend bits shift out of the quotient register as quotient bits shift in.
    assign rem_sh = {rem_q, quo_q[W-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        unique case (state_q)
            DivIdle: begin
                if (start_i) begin
                    state_d = DivBusy;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dividend_i;
                    div_d   = divisor_i;
                end
            end
            DivBusy: begin
                if (rem_sh >= {1'b0, div_q}) begin
                    rem_d = (W+1)'(rem_sh - {1'b0, div_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[W:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = DivIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DivIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/frequency_generator.sv
// Square-wave generator: Load/Ready handshake, pending setting, STOP/RUN output FSM and
// half-period counter; the half period comes from the sequential divider.
module frequency_generator
    import frequency_generator_pkg::*;
#(
    parameter int unsigned CLK_HZ = FG_CLK_HZ,
    parameter int unsigned W      = FG_W
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [W-1:0] Freq,
    input  logic         Load,
    input  logic         En,
    output logic         Sig,
    output logic         Ready,
    output logic         Active
);

    localparam logic [W-1:0] ClkHz = W'(CLK_HZ);

    fsm_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] hp_q, hp_d;
    logic [W-1:0] pend_hp_q, pend_hp_d;
    logic         pend_stop_q, pend_stop_d;
    logic         pend_valid_q, pend_valid_d;
    logic         busy_q, busy_d;
    logic         load_stop_q, load_stop_d;
    logic         sig_q, sig_d;

    logic         load_acc;
    logic         div_done;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_hp;

    assign load_acc = Load & ~busy_q;
    assign div_hp   = (div_quo == '0) ? W'(1) : div_quo;

    freq_div #(
        .W (W)
    ) u_freq_div (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .start_i    (load_acc),
        .dividend_i (ClkHz),
        .divisor_i  ({Freq, 1'b0}),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hp_d         = hp_q;
        pend_hp_d    = pend_hp_q;
        pend_stop_d  = pend_stop_q;
        pend_valid_d = pend_valid_q;
        busy_d       = busy_q;
        load_stop_d  = load_stop_q;
        sig_d        = sig_q;

        if (load_acc) begin
            busy_d      = 1'b1;
            load_stop_d = (Freq == '0);
        end

        unique case (state_q)
            StStop: begin
                sig_d = 1'b0;
                cnt_d = '0;
                if (pend_valid_q) begin
                    if (pend_stop_q) begin
                        pend_valid_d = 1'b0;
                    end else if (En) begin
                        state_d      = StRun;
                        hp_d         = pend_hp_q;
                        sig_d        = 1'b1;
                        pend_valid_d = 1'b0;
                    end
                end
            end
            StRun: begin
                if (!En) begin
                    state_d = StStop;
                    sig_d   = 1'b0;
                    cnt_d   = '0;
                    // Keep the running setting for restart unless a newer one is waiting.
                    if (!pend_valid_q) begin
                        pend_hp_d    = hp_q;
                        pend_stop_d  = 1'b0;
                        pend_valid_d = 1'b1;
                    end
                end else if (cnt_q == hp_q - W'(1)) begin
                    cnt_d = '0;
                    if (!sig_q && pend_valid_q) begin
                        pend_valid_d = 1'b0;
                        if (pend_stop_q) begin
                            state_d = StStop;
                            sig_d   = 1'b0;
                        end else begin
                            hp_d  = pend_hp_q;
                            sig_d = 1'b1;
                        end
                    end else begin
                        sig_d = ~sig_q;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
        endcase

        // A fresh result always wins over whatever was pending.
        if (div_done) begin
            busy_d       = 1'b0;
            pend_hp_d    = div_hp;
            pend_stop_d  = load_stop_q;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= StStop;
            cnt_q        <= '0;
            hp_q         <= '0;
            pend_hp_q    <= '0;
            pend_stop_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            load_stop_q  <= 1'b0;
            sig_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hp_q         <= hp_d;
            pend_hp_q    <= pend_hp_d;
            pend_stop_q  <= pend_stop_d;
            pend_valid_q <= pend_valid_d;
            busy_q       <= busy_d;
            load_stop_q  <= load_stop_d;
            sig_q        <= sig_d;
        end
    end

    assign Sig    = sig_q;
    assign Ready  = ~busy_q;
    assign Active = (state_q == StRun);

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench: half periods from CLK_HZ/(2*Freq) arithmetic, waveform measured on Sig.
module tb_frequency_generator;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned W      = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] freq = '0;
    logic        load = 1'b0;
    logic        en = 1'b1;
    logic        sig, ready, active;

    logic [31:0] freq2 = '0;
    logic        load2 = 1'b0;
    logic        sig2, ready2, active2;

    int total = 0;
    int bad   = 0;
    int cur_hp = 0;

    always #5 clk = ~clk;

    frequency_generator #(
        .CLK_HZ (CLK_HZ),
        .W      (W)
    ) dut (
        .Clk    (clk),
        .Rst    (rst),
        .Freq   (freq),
        .Load   (load),
        .En     (en),
        .Sig    (sig),
        .Ready  (ready),
        .Active (active)
    );

    frequency_generator #(
        .CLK_HZ (100_000_000),
        .W      (32)
    ) dut_fast (
        .Clk    (clk),
        .Rst    (rst),
        .Freq   (freq2),
        .Load   (load2),
        .En     (en),
        .Sig    (sig2),
        .Ready  (ready2),
        .Active (active2)
    );

    function automatic int model_hp(input longint f);
        longint q;
        if (f == 0) return 0;
        q = longint'(CLK_HZ) / (2 * f);
        return (q == 0) ? 1 : int'(q);
    endfunction

    task automatic run_len(input logic level, output int len);
        len = 0;
        while (sig === level && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [31:0] f);
        freq = f;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Counts Ready-low cycles and checks every complete phase seen meanwhile uses old_hp.
    task automatic wait_ready(input int start_low, input int old_hp, input string name);
        int   low;
        int   run;
        logic prev;
        bit   seen;
        low  = start_low;
        run  = 0;
        prev = sig;
        seen = 0;
        while (ready !== 1'b1 && low < 200) begin
            if (sig !== prev) begin
                if (seen) begin
                    total++;
                    if (run !== old_hp) begin
                        bad++;
                        $display("FAIL %s_old_phase: got %0d expected %0d", name, run, old_hp);
                    end
                end
                seen = 1;
                run  = 0;
                prev = sig;
            end
            run++;
            low++;
            @(negedge clk);
        end
        total++;
        if (low !== 33) begin
            bad++;
            $display("FAIL %s_ready_low: got %0d expected %0d", name, low, 33);
        end
    endtask

    task automatic check_new(input int exp, input string name);
        logic prev;
        bit   found;
        int   h;
        int   l;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            prev = sig;
            @(negedge clk);
            if (prev === 1'b0 && sig === 1'b1) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s_rise: got %0d expected %0d", name, 0, 1);
        end
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL %s_active: got %0d expected %0d", name, active, 1);
        end
        run_len(1'b1, h);
        total++;
        if (h !== exp) begin
            bad++;
            $display("FAIL %s_high: got %0d expected %0d", name, h, exp);
        end
        run_len(1'b0, l);
        total++;
        if (l !== exp) begin
            bad++;
            $display("FAIL %s_low: got %0d expected %0d", name, l, exp);
        end
        cur_hp = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (sig !== 1'b0 || ready !== 1'b1 || active !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got %0d%0d%0d expected 010", sig, ready, active);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_load(32'd100);
        wait_ready(0, 0, "basic");
        total++;
        if (sig !== 1'b0) begin
            bad++;
            $display("FAIL basic_pre_commit: got %0d expected %0d", sig, 0);
        end
        @(negedge clk);
        total++;
        if (sig !== 1'b1 || active !== 1'b1) begin
            bad++;
            $display("FAIL basic_first_high: got %0d%0d expected 11", sig, active);
        end
        begin
            int h;
            int l;
            run_len(1'b1, h);
            run_len(1'b0, l);
            total++;
            if (h !== 5 || l !== 5) begin
                bad++;
                $display("FAIL basic_period: got %0d/%0d expected 5/5", h, l);
            end
        end
        cur_hp = 5;
    endtask

    task automatic test_switch(input logic [31:0] f, input bit sync_high, input string name);
        if (sync_high) begin
            logic prev;
            for (int i = 0; i < 3000; i++) begin
                prev = sig;
                @(negedge clk);
                if (prev === 1'b0 && sig === 1'b1) break;
            end
            @(negedge clk);
        end else begin
            repeat ($urandom_range(0, 2 * cur_hp)) @(negedge clk);
        end
        do_load(f);
        wait_ready(0, cur_hp, name);
        check_new(model_hp(longint'(f)), name);
    endtask

    task automatic test_ignore();
        do_load(32'd100);
        repeat (5) @(negedge clk);
        freq = 32'd7;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_ready(6, cur_hp, "ignore");
        check_new(model_hp(100), "ignore");
    endtask

    task automatic test_stop();
        bit found;
        int viol;
        do_load(32'd0);
        wait_ready(0, cur_hp, "stop");
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (active === 1'b0) found = 1;
        end
        total++;
        if (!found || sig !== 1'b0) begin
            bad++;
            $display("FAIL stop_enter: got %0d%0d expected 10", found, sig);
        end
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (sig !== 1'b0 || active !== 1'b0) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL stop_hold: got %0d expected %0d", viol, 0);
        end
        cur_hp = 0;
    endtask

    task automatic test_enable();
        int h;
        do_load(32'd100);
        wait_ready(0, 0, "enable_load");
        check_new(5, "enable_load");
        repeat ($urandom_range(0, 9)) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        total++;
        if (sig !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL enable_off: got %0d%0d expected 00", sig, active);
        end
        repeat ($urandom_range(1, 6)) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        total++;
        if (sig !== 1'b1 || active !== 1'b1) begin
            bad++;
            $display("FAIL enable_on: got %0d%0d expected 11", sig, active);
        end
        run_len(1'b1, h);
        total++;
        if (h !== 5) begin
            bad++;
            $display("FAIL enable_high: got %0d expected %0d", h, 5);
        end
    endtask

    task automatic test_reset_mid();
        int viol;
        do_load(32'd37);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (sig !== 1'b0 || ready !== 1'b1 || active !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got %0d%0d%0d expected 010", sig, ready, active);
        end
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (sig !== 1'b0 || active !== 1'b0 || ready !== 1'b1) viol++;
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL reset_quiet: got %0d expected %0d", viol, 0);
        end
        cur_hp = 0;
    endtask

    task automatic test_loopback();
        logic prev;
        int   edges;
        int   period;
        int   cyc;
        freq2 = 32'd1_000_000;
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        edges  = 0;
        period = 0;
        cyc    = 0;
        prev   = sig2;
        for (int i = 0; i < 600 && edges < 2; i++) begin
            @(negedge clk);
            cyc++;
            if (prev === 1'b0 && sig2 === 1'b1) begin
                if (edges == 1) period = cyc;
                edges++;
                cyc = 0;
            end
            prev = sig2;
        end
        total++;
        if (period !== 100 || active2 !== 1'b1) begin
            bad++;
            $display("FAIL loopback_period: got %0d expected %0d", period, 100);
        end
        total++;
        if (period == 0 || (100_000_000 / period) !== 1_000_000) begin
            bad++;
            $display("FAIL loopback_freq: got %0d expected %0d",
                     (period == 0) ? 0 : 100_000_000 / period, 1_000_000);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_switch(32'd50, 1'b1, "slower");
        test_ignore();
        test_switch(32'd600, 1'b0, "clamp");
        for (int k = 0; k < 6; k++) begin
            test_switch(32'($urandom_range(2, 700)), 1'b0, "random");
        end
        test_stop();
        test_enable();
        test_reset_mid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
